// File: rtl/iagc_controller.sv
// ---------------------------------------------------------------------------
// iagc_controller
//
// Purpose:
//   Automatic gain control sequencer for the amplitude_detector loop. After
//   reset it waits a fixed number of cycles (RESET), then waits for the
//   detector's first update (INIT). If that update does not arrive, it stops
//   in FAULT with a sticky error flag. Once in IDLE, every detector update
//   whose error lies outside the deadband starts a one-cycle ADJUST. ADJUST
//   moves the gain by GAIN_STEP against the sign of the error and saturates
//   at the ends of the gain range.
//
// Ports:
//   i_clock          single clock, rising edge
//   i_resetN         asynchronous active-low reset
//   i_enable         permits gain adjustment while IDLE
//   i_restart        synchronous request to re-run the RESET/INIT sequence
//   i_update         one-cycle pulse: new amplitude values available
//   i_errorAmplitude two's-complement error (measured minus reference)
//   o_iagcStatus     registered state code, feeds amplitude_detector
//   o_gain           registered unsigned gain word
//   o_gainValid      one-cycle pulse on the edge that leaves ADJUST
//   o_error          sticky init-timeout flag
//   o_locked         lock indication (constant 0 unless lock detect built in)
//
// Build option:
//   IAGC_LOCK_DETECT_EN - when defined, o_locked asserts after LOCK_COUNT
//   consecutive in-deadband updates in IDLE. It clears on any ADJUST, on
//   restart, or on reset.
// ---------------------------------------------------------------------------
module iagc_controller #(
  parameter int IAGC_STATUS_SIZE    = 4,
  parameter int AMPLITUDE_DATA_SIZE = 16,
  parameter int GAIN_SIZE           = 8,
  parameter int RESET_CYCLES        = 4,
  parameter int INIT_TIMEOUT        = 32,
  parameter int DEADBAND            = 8,
  parameter int GAIN_STEP           = 4,
  parameter int GAIN_INIT           = 128,
  parameter int LOCK_COUNT          = 3
) (
  input  logic                           i_clock,
  input  logic                           i_resetN,
  input  logic                           i_enable,
  input  logic                           i_restart,
  input  logic                           i_update,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_errorAmplitude,
  output logic [IAGC_STATUS_SIZE-1:0]    o_iagcStatus,
  output logic [GAIN_SIZE-1:0]           o_gain,
  output logic                           o_gainValid,
  output logic                           o_error,
  output logic                           o_locked
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0000,
    ST_INIT   = 4'b0001,
    ST_IDLE   = 4'b0010,
    ST_ADJUST = 4'b0011,
    ST_FAULT  = 4'b1111
  } state_t;

  localparam int CNT_MAX = (RESET_CYCLES > INIT_TIMEOUT) ? RESET_CYCLES : INIT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int AW      = AMPLITUDE_DATA_SIZE + 1;

  localparam logic [AW-1:0]        LP_DEADBAND = AW'(DEADBAND);
  localparam logic [GAIN_SIZE:0]   LP_STEP     = (GAIN_SIZE + 1)'(GAIN_STEP);
  localparam logic [GAIN_SIZE:0]   LP_GMAX     = {1'b0, {GAIN_SIZE{1'b1}}};
  localparam logic [GAIN_SIZE-1:0] LP_GINIT    = GAIN_SIZE'(GAIN_INIT);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [GAIN_SIZE-1:0] r_gain;
  logic                 r_gainValid;
  logic                 r_error;
  logic                 r_dirUp;

`ifdef IAGC_LOCK_DETECT_EN
  localparam int LK_W = $clog2(LOCK_COUNT + 1);
  logic [LK_W-1:0]      r_lockCnt;
  logic                 r_locked;
`endif

  logic                 w_errNeg;
  logic [AW-1:0]        w_errExt;
  logic [AW-1:0]        w_errMag;
  logic                 w_outside;
  logic [GAIN_SIZE:0]   w_gainExt;
  logic [GAIN_SIZE:0]   w_gainUp;
  logic [GAIN_SIZE-1:0] w_gainNext;

  // The magnitude uses one extra bit so that the most negative input has a
  // representable absolute value. That value counts as a large negative error.
  always_comb begin
    w_errNeg  = i_errorAmplitude[AMPLITUDE_DATA_SIZE-1];
    w_errExt  = {w_errNeg, i_errorAmplitude};
    w_errMag  = w_errNeg ? (~w_errExt + AW'(1)) : w_errExt;
    w_outside = (w_errMag > LP_DEADBAND);
  end

  // Saturating step, computed one bit wider than the gain word.
  always_comb begin
    w_gainExt  = {1'b0, r_gain};
    w_gainUp   = w_gainExt + LP_STEP;
    w_gainNext = r_gain;
    if (r_dirUp) begin
      if (w_gainUp > LP_GMAX) begin
        w_gainNext = '1;
      end else begin
        w_gainNext = GAIN_SIZE'(w_gainUp);
      end
    end else begin
      if (w_gainExt < LP_STEP) begin
        w_gainNext = '0;
      end else begin
        w_gainNext = GAIN_SIZE'(w_gainExt - LP_STEP);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_gain      <= LP_GINIT;
      r_gainValid <= 1'b0;
      r_error     <= 1'b0;
      r_dirUp     <= 1'b0;
`ifdef IAGC_LOCK_DETECT_EN
      r_lockCnt   <= '0;
      r_locked    <= 1'b0;
`endif
    end else begin
      r_gainValid <= 1'b0;
      if (i_restart) begin
        // Restart takes priority over any update in the same cycle. It also
        // drops a gain change that is pending in ADJUST.
        r_state <= ST_RESET;
        r_cnt   <= '0;
        r_gain  <= LP_GINIT;
        r_error <= 1'b0;
`ifdef IAGC_LOCK_DETECT_EN
        r_lockCnt <= '0;
        r_locked  <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_RESET: begin
            if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
              r_state <= ST_INIT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_INIT: begin
            if (i_update) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_W'(INIT_TIMEOUT - 1)) begin
              r_state <= ST_FAULT;
              r_error <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_IDLE: begin
            if (i_update) begin
              if (i_enable && w_outside) begin
                // Store the direction now. The gain changes on the exit edge.
                r_state <= ST_ADJUST;
                r_dirUp <= w_errNeg;
`ifdef IAGC_LOCK_DETECT_EN
                r_lockCnt <= '0;
                r_locked  <= 1'b0;
`endif
              end
`ifdef IAGC_LOCK_DETECT_EN
              else if (!w_outside) begin
                if (r_lockCnt < LK_W'(LOCK_COUNT)) begin
                  r_lockCnt <= r_lockCnt + LK_W'(1);
                end
                if (r_lockCnt >= LK_W'(LOCK_COUNT - 1)) begin
                  r_locked <= 1'b1;
                end
              end
`endif
            end
          end
          ST_ADJUST: begin
            r_gain      <= w_gainNext;
            r_gainValid <= 1'b1;
            r_state     <= ST_IDLE;
          end
          ST_FAULT: begin
            r_state <= ST_FAULT;
          end
          default: begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_iagcStatus = IAGC_STATUS_SIZE'(r_state);
  assign o_gain       = r_gain;
  assign o_gainValid  = r_gainValid;
  assign o_error      = r_error;
`ifdef IAGC_LOCK_DETECT_EN
  assign o_locked     = r_locked;
`else
  assign o_locked     = 1'b0;
`endif

endmodule

// File: tb/tb_iagc_controller.sv
// ---------------------------------------------------------------------------
// tb_iagc_controller
//
// Testbench for iagc_controller. A cycle-level reference model written with
// plain integer arithmetic runs alongside the DUT. All outputs are compared
// 1 ns after each rising edge. Directed sequences cover the timeout, the
// gain step, saturation, the deadband edge, restart priority, lock detect
// and asynchronous reset during ADJUST. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_iagc_controller;

  localparam int RESET_CYCLES = 4;
  localparam int INIT_TIMEOUT = 32;
  localparam int DEADBAND     = 8;
  localparam int GAIN_STEP    = 4;
  localparam int GAIN_INIT    = 128;
  localparam int LOCK_COUNT   = 3;
  localparam int GAIN_MAX     = 255;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        restart;
  logic        upd;
  logic [15:0] err;
  logic [3:0]  status;
  logic [7:0]  gain;
  logic        gain_valid;
  logic        error_flag;
  logic        locked;

  int n_checks;
  int n_errors;

  // reference model state
  int m_status;
  int m_timer;
  int m_gain;
  int m_pend;
  int m_lockRun;
  int m_valid;
  int m_error;
  int m_locked;

  iagc_controller #(
    .IAGC_STATUS_SIZE    (4),
    .AMPLITUDE_DATA_SIZE (16),
    .GAIN_SIZE           (8),
    .RESET_CYCLES        (RESET_CYCLES),
    .INIT_TIMEOUT        (INIT_TIMEOUT),
    .DEADBAND            (DEADBAND),
    .GAIN_STEP           (GAIN_STEP),
    .GAIN_INIT           (GAIN_INIT),
    .LOCK_COUNT          (LOCK_COUNT)
  ) dut (
    .i_clock          (clk),
    .i_resetN         (rst_n),
    .i_enable         (en),
    .i_restart        (restart),
    .i_update         (upd),
    .i_errorAmplitude (err),
    .o_iagcStatus     (status),
    .o_gain           (gain),
    .o_gainValid      (gain_valid),
    .o_error          (error_flag),
    .o_locked         (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status  = 0;
    m_timer   = 0;
    m_gain    = GAIN_INIT;
    m_pend    = 0;
    m_lockRun = 0;
    m_valid   = 0;
    m_error   = 0;
    m_locked  = 0;
  endtask

  function automatic int clamp_gain(input int g);
    if (g < 0) return 0;
    if (g > GAIN_MAX) return GAIN_MAX;
    return g;
  endfunction

  // One rising edge of the reference model. It reads the current inputs.
  task automatic model_edge();
    int e;
    int mag;
    e   = int'($signed(err));
    mag = (e < 0) ? -e : e;
    m_valid = 0;
    if (restart) begin
      m_status  = 0;
      m_timer   = 0;
      m_gain    = GAIN_INIT;
      m_error   = 0;
      m_locked  = 0;
      m_lockRun = 0;
    end else if (m_status == 0) begin
      m_timer++;
      if (m_timer == RESET_CYCLES) begin
        m_status = 1;
        m_timer  = 0;
      end
    end else if (m_status == 1) begin
      if (upd) begin
        m_status = 2;
        m_timer  = 0;
      end else begin
        m_timer++;
        if (m_timer == INIT_TIMEOUT) begin
          m_status = 15;
          m_error  = 1;
        end
      end
    end else if (m_status == 2) begin
      if (upd) begin
        if (en && mag > DEADBAND) begin
          m_status  = 3;
          m_pend    = (e > 0) ? -GAIN_STEP : GAIN_STEP;
          m_lockRun = 0;
          m_locked  = 0;
        end else if (mag <= DEADBAND) begin
          m_lockRun++;
`ifdef IAGC_LOCK_DETECT_EN
          if (m_lockRun >= LOCK_COUNT) m_locked = 1;
`endif
        end
      end
    end else if (m_status == 3) begin
      m_gain   = clamp_gain(m_gain + m_pend);
      m_valid  = 1;
      m_status = 2;
    end
  endtask

  task automatic compare_all();
    check("status", status, m_status);
    check("gain", gain, m_gain);
    check("gain_valid", gain_valid, m_valid);
    check("error", error_flag, m_error);
    check("locked", locked, m_locked);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_update(input int e);
    err = 16'(e);
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  // Restart, wait out RESET and enter IDLE on the first INIT update.
  task automatic restart_to_idle();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i < RESET_CYCLES; i++) tick();
    pulse_update(0);
    check("reach_idle", status, 2);
  endtask

  function automatic int pick_error();
    case ($urandom_range(0, 7))
      0: return DEADBAND;
      1: return -DEADBAND;
      2: return DEADBAND + 1;
      3: return -(DEADBAND + 1);
      4: return 32'h8000;
      5: return 32'h7FFF;
      6: return int'($urandom_range(0, 40)) - 20;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    restart = 1'b0;
    upd     = 1'b0;
    err     = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("reset_status", status, 0);
    check("reset_gain", gain, GAIN_INIT);

    // no update: 4 cycles RESET, 32 cycles INIT, then FAULT
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= RESET_CYCLES + INIT_TIMEOUT + 2; i++) begin
      tick();
      if (i == RESET_CYCLES - 1) check("still_reset", status, 0);
      if (i == RESET_CYCLES) check("enter_init", status, 1);
      if (i == RESET_CYCLES + INIT_TIMEOUT - 1) check("still_init", status, 1);
      if (i == RESET_CYCLES + INIT_TIMEOUT) begin
        check("enter_fault", status, 15);
        check("fault_error", error_flag, 1);
      end
    end
    check("fault_sticky", status, 15);

    // first adjustment: +20 -> 128 - 4
    restart_to_idle();
    check("restart_clears_error", error_flag, 0);
    pulse_update(20);
    check("adjust_state", status, 3);
    check("adjust_no_valid_yet", gain_valid, 0);
    tick();
    check("gain_dec", gain, 124);
    check("gain_valid_pulse", gain_valid, 1);
    check("back_idle", status, 2);
    tick();
    check("gain_valid_one_cycle", gain_valid, 0);

    // climb to 252, then saturate at 255
    for (int i = 0; i < 32; i++) begin
      pulse_update(-100);
      tick();
    end
    check("gain_252", gain, 252);
    pulse_update(-100);
    tick();
    check("gain_sat", gain, 255);
    check("gain_sat_valid", gain_valid, 1);
    pulse_update(-100);
    tick();
    check("gain_sat_hold", gain, 255);
    check("gain_sat_hold_valid", gain_valid, 1);
    pulse_update(DEADBAND);
    check("deadband_pos_no_adjust", status, 2);
    tick();
    pulse_update(-DEADBAND);
    check("deadband_neg_no_adjust", status, 2);
    tick();
    pulse_update(32'h8000);
    check("most_negative_adjusts", status, 3);
    tick();
    check("most_negative_gain", gain, 255);

    // enable low freezes gain in IDLE
    en = 1'b0;
    pulse_update(500);
    check("disabled_stays_idle", status, 2);
    tick();
    en = 1'b1;

    // restart wins over a simultaneous update
    err     = 16'(50);
    upd     = 1'b1;
    restart = 1'b1;
    tick();
    upd     = 1'b0;
    restart = 1'b0;
    check("restart_status", status, 0);
    check("restart_gain", gain, GAIN_INIT);
    check("restart_no_valid", gain_valid, 0);

    // lock detection
    for (int i = 0; i < RESET_CYCLES; i++) tick();
    pulse_update(0);
    for (int i = 0; i < 3; i++) begin
      pulse_update(3);
      tick();
    end
`ifdef IAGC_LOCK_DETECT_EN
    check("locked_set", locked, 1);
`else
    check("locked_absent", locked, 0);
`endif
    pulse_update(-30);
    check("locked_clear", locked, 0);
    tick();
    check("gain_132", gain, 132);

    // randomized phase
    restart_to_idle();
    for (int i = 0; i < 3000; i++) begin
      restart = ($urandom_range(0, 99) < 2);
      upd     = ($urandom_range(0, 99) < 40);
      en      = ($urandom_range(0, 99) < 80);
      err     = 16'(pick_error());
      tick();
    end
    restart = 1'b0;
    upd     = 1'b0;
    en      = 1'b1;

    // async reset during ADJUST discards the pending change
    restart_to_idle();
    pulse_update(50);
    check("pre_reset_adjust", status, 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_status", status, 0);
    check("async_gain", gain, GAIN_INIT);
    check("async_valid", gain_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_reset_gain", gain, GAIN_INIT);
    check("after_reset_valid", gain_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
